// File: rtl/reg_file_wb_pkg.sv
// Shared pipeline constants for the register file and its load scoreboard.
// Holds default widths and the hard-wired zero register index.
package reg_file_wb_pkg;

  localparam int RF_DATA_W   = 32;
  localparam int RF_ADDR_W   = 5;
  localparam int RF_ZERO_REG = 0;

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register busy tracking for in-flight loads; raises load-use stall.
// Ports: clk, reset, ld_issue/ld_dst (set), reg_write/wb_dst (clear),
//        rs_addr/rt_addr (query), stall (combinational).
module reg_scoreboard
  import reg_file_wb_pkg::*;
#(
  parameter int ADDR_W = RF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ld_issue,
  input  logic [ADDR_W-1:0] ld_dst,
  input  logic              reg_write,
  input  logic [ADDR_W-1:0] wb_dst,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic              stall
);

  localparam int NREG = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO = ADDR_W'(RF_ZERO_REG);

  logic [NREG-1:0] busy_q, busy_d;
  logic            rs_hit, rt_hit;

  // Clear first so a same-register set in this cycle wins.
  always_comb begin
    busy_d = busy_q;
    if (reg_write)
      busy_d[wb_dst] = 1'b0;
    if (ld_issue && (ld_dst != ZERO))
      busy_d[ld_dst] = 1'b1;
  end

  // A write-back landing this cycle satisfies the waiting read.
  always_comb begin
    rs_hit = (rs_addr != ZERO) && busy_q[rs_addr]
           && !(reg_write && (wb_dst == rs_addr));
    rt_hit = (rt_addr != ZERO) && busy_q[rt_addr]
           && !(reg_write && (wb_dst == rt_addr));
    stall  = rs_hit || rt_hit;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      busy_q <= '0;
    else
      busy_q <= busy_d;
  end

endmodule

// File: rtl/reg_file_wb.sv
// Two-read, one-write register file with write-through bypass and r0 = 0.
// Ports: clk, reset, reg_write/wb_dst/wb_data, rs/rt addr+data,
//        ld_issue/ld_dst, stall.
module reg_file_wb
  import reg_file_wb_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              reg_write,
  input  logic [ADDR_W-1:0] wb_dst,
  input  logic [DATA_W-1:0] wb_data,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  input  logic              ld_issue,
  input  logic [ADDR_W-1:0] ld_dst,
  output logic              stall
);

  localparam int NREG = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO = ADDR_W'(RF_ZERO_REG);

  logic [DATA_W-1:0] regs_q [NREG];
  logic [DATA_W-1:0] regs_d [NREG];
  logic              wr_en;

  assign wr_en = reg_write && (wb_dst != ZERO);

  always_comb begin
    regs_d = regs_q;
    if (wr_en)
      regs_d[wb_dst] = wb_data;
  end

  // r0 is never written, so its entry stays 0.
  always_comb begin
    rs_data = regs_q[rs_addr];
    if (wr_en && (wb_dst == rs_addr))
      rs_data = wb_data;
    rt_data = regs_q[rt_addr];
    if (wr_en && (wb_dst == rt_addr))
      rt_data = wb_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++)
        regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  reg_scoreboard #(
    .ADDR_W(ADDR_W)
  ) u_sb (
    .clk      (clk),
    .reset    (reset),
    .ld_issue (ld_issue),
    .ld_dst   (ld_dst),
    .reg_write(reg_write),
    .wb_dst   (wb_dst),
    .rs_addr  (rs_addr),
    .rt_addr  (rt_addr),
    .stall    (stall)
  );

endmodule

// File: tb/tb_reg_file_wb.sv
// Directed bench for reg_file_wb: expectations queued by the stimulus,
// compared by an independent monitor when each observation is presented.
module tb_reg_file_wb;

  logic        clk = 1'b0;
  logic        reset;
  logic        reg_write;
  logic [4:0]  wb_dst;
  logic [31:0] wb_data;
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        ld_issue;
  logic [4:0]  ld_dst;
  logic        stall;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string       name;
    logic [31:0] rs;
    logic [31:0] rt;
    logic        st;
  } exp_t;

  exp_t q[$];
  event obs;

  always #5 clk = ~clk;

  reg_file_wb dut (
    .clk      (clk),
    .reset    (reset),
    .reg_write(reg_write),
    .wb_dst   (wb_dst),
    .wb_data  (wb_data),
    .rs_addr  (rs_addr),
    .rt_addr  (rt_addr),
    .rs_data  (rs_data),
    .rt_data  (rt_data),
    .ld_issue (ld_issue),
    .ld_dst   (ld_dst),
    .stall    (stall)
  );

  // Monitor: pops one expectation per presented observation.
  initial begin
    exp_t e;
    forever begin
      @(obs);
      if (q.size() == 0) begin
        failures++;
        $display("FAIL monitor: observation with empty queue");
      end else begin
        e = q.pop_front();
        checks++;
        if (rs_data !== e.rs) begin
          failures++;
          $display("FAIL %s rs_data got %h want %h", e.name, rs_data, e.rs);
        end
        checks++;
        if (rt_data !== e.rt) begin
          failures++;
          $display("FAIL %s rt_data got %h want %h", e.name, rt_data, e.rt);
        end
        checks++;
        if (stall !== e.st) begin
          failures++;
          $display("FAIL %s stall got %b want %b", e.name, stall, e.st);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] ers,
                     input logic [31:0] ert, input logic est);
    exp_t e;
    #1;
    e.name = nm;
    e.rs   = ers;
    e.rt   = ert;
    e.st   = est;
    q.push_back(e);
    -> obs;
    #1;
  endtask

  task automatic idle();
    reg_write = 1'b0;
    wb_dst    = '0;
    wb_data   = '0;
    ld_issue  = 1'b0;
    ld_dst    = '0;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    idle();
    rs_addr = '0;
    rt_addr = '0;
    @(negedge clk);
    chk("in_reset", 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      rs_addr = 5'(i);
      rt_addr = 5'(31 - i);
      chk($sformatf("rst_read_%0d", i), 32'h0, 32'h0, 1'b0);
    end

    // Write-through to r5, then read from storage.
    @(negedge clk);
    reg_write = 1'b1; wb_dst = 5'd5; wb_data = 32'hDEADBEEF;
    rs_addr = 5'd5; rt_addr = 5'd0;
    chk("wt_r5", 32'hDEADBEEF, 32'h0, 1'b0);
    @(negedge clk);
    idle();
    chk("held_r5", 32'hDEADBEEF, 32'h0, 1'b0);

    // r0 ignores writes.
    @(negedge clk);
    reg_write = 1'b1; wb_dst = 5'd0; wb_data = 32'h12345678;
    rs_addr = 5'd0; rt_addr = 5'd0;
    chk("r0_during", 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    idle();
    chk("r0_after", 32'h0, 32'h0, 1'b0);

    // Both ports bypass independently.
    @(negedge clk);
    reg_write = 1'b1; wb_dst = 5'd6; wb_data = 32'hCAFEF00D;
    rs_addr = 5'd6; rt_addr = 5'd6;
    chk("dual_bypass", 32'hCAFEF00D, 32'hCAFEF00D, 1'b0);
    rs_addr = 5'd5;
    chk("mixed_bypass", 32'hDEADBEEF, 32'hCAFEF00D, 1'b0);

    // Load-use on r7, released by write-back.
    @(negedge clk);
    idle();
    ld_issue = 1'b1; ld_dst = 5'd7;
    rs_addr = 5'd0; rt_addr = 5'd7;
    chk("ld7_issue", 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    idle();
    chk("ld7_stall", 32'h0, 32'h0, 1'b1);
    @(negedge clk);
    reg_write = 1'b1; wb_dst = 5'd7; wb_data = 32'h55;
    chk("ld7_release", 32'h0, 32'h55, 1'b0);
    @(negedge clk);
    idle();
    chk("ld7_after", 32'h0, 32'h55, 1'b0);

    // Same-register set and clear: set wins.
    @(negedge clk);
    ld_issue = 1'b1; ld_dst = 5'd9;
    reg_write = 1'b1; wb_dst = 5'd9; wb_data = 32'h99;
    rs_addr = 5'd9; rt_addr = 5'd0;
    chk("setclr9_same", 32'h99, 32'h0, 1'b0);
    @(negedge clk);
    idle();
    chk("setclr9_busy", 32'h99, 32'h0, 1'b1);

    // Different-register set and clear both apply.
    @(negedge clk);
    ld_issue = 1'b1; ld_dst = 5'd10;
    reg_write = 1'b1; wb_dst = 5'd9; wb_data = 32'h111;
    rs_addr = 5'd9; rt_addr = 5'd10;
    chk("setclr_diff", 32'h111, 32'h0, 1'b0);
    @(negedge clk);
    idle();
    chk("diff_r10_busy", 32'h111, 32'h0, 1'b1);
    rt_addr = 5'd0;
    chk("diff_r9_free", 32'h111, 32'h0, 1'b0);

    // Re-issue to busy r10; one write-back clears it.
    @(negedge clk);
    ld_issue = 1'b1; ld_dst = 5'd10;
    rs_addr = 5'd0; rt_addr = 5'd0;
    chk("reissue10", 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    idle();
    rt_addr = 5'd10;
    chk("reissue10_busy", 32'h0, 32'h0, 1'b1);
    @(negedge clk);
    reg_write = 1'b1; wb_dst = 5'd10; wb_data = 32'hA;
    chk("r10_release", 32'h0, 32'hA, 1'b0);
    @(negedge clk);
    idle();
    chk("r10_clear", 32'h0, 32'hA, 1'b0);

    // Load to r0 never marks busy.
    @(negedge clk);
    ld_issue = 1'b1; ld_dst = 5'd0;
    rs_addr = 5'd0; rt_addr = 5'd0;
    @(negedge clk);
    idle();
    chk("ld_r0", 32'h0, 32'h0, 1'b0);

    // Asynchronous reset between edges.
    @(negedge clk);
    reg_write = 1'b1; wb_dst = 5'd3; wb_data = 32'hA5;
    ld_issue = 1'b1; ld_dst = 5'd4;
    chk("pre_rst_wr", 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    idle();
    rs_addr = 5'd3; rt_addr = 5'd4;
    chk("pre_rst_state", 32'hA5, 32'h0, 1'b1);
    reset = 1'b1;
    chk("async_rst", 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    reg_write = 1'b1; wb_dst = 5'd3; wb_data = 32'h77;
    ld_issue = 1'b1; ld_dst = 5'd12;
    rs_addr = 5'd3; rt_addr = 5'd12;
    chk("rst_bypass", 32'h77, 32'h0, 1'b0);
    @(negedge clk);
    idle();
    reset = 1'b0;
    chk("rst_ignored", 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    reg_write = 1'b1; wb_dst = 5'd3; wb_data = 32'h3C;
    rs_addr = 5'd3; rt_addr = 5'd4;
    chk("post_rst_wr", 32'h3C, 32'h0, 1'b0);
    @(negedge clk);
    idle();
    chk("post_rst_rd", 32'h3C, 32'h0, 1'b0);

    @(negedge clk);
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
